// File: rtl/axi4_to_tlul.sv
// rtl/axi4_to_tlul.sv - AXI4 slave to TL-UL host bridge, one outstanding single-beat transaction.
// Define AXI4_TLUL_ALIGN_CHECK_EN to reject addresses not aligned to the transfer size.
module axi4_to_tlul #(
  parameter int DataWidth   = 64,
  parameter int AddrWidth   = 32,
  parameter int IdWidth     = 8,
  parameter int SourceWidth = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [IdWidth-1:0]       axi_awid,
  input  logic [AddrWidth-1:0]     axi_awaddr,
  input  logic [7:0]               axi_awlen,
  input  logic [2:0]               axi_awsize,
  input  logic [1:0]               axi_awburst,
  input  logic                     axi_awvalid,
  output logic                     axi_awready,
  input  logic [DataWidth-1:0]     axi_wdata,
  input  logic [DataWidth/8-1:0]   axi_wstrb,
  input  logic                     axi_wlast,
  input  logic                     axi_wvalid,
  output logic                     axi_wready,
  output logic [IdWidth-1:0]       axi_bid,
  output logic [1:0]               axi_bresp,
  output logic                     axi_bvalid,
  input  logic                     axi_bready,
  input  logic [IdWidth-1:0]       axi_arid,
  input  logic [AddrWidth-1:0]     axi_araddr,
  input  logic [7:0]               axi_arlen,
  input  logic [2:0]               axi_arsize,
  input  logic [1:0]               axi_arburst,
  input  logic                     axi_arvalid,
  output logic                     axi_arready,
  output logic [IdWidth-1:0]       axi_rid,
  output logic [DataWidth-1:0]     axi_rdata,
  output logic [1:0]               axi_rresp,
  output logic                     axi_rlast,
  output logic                     axi_rvalid,
  input  logic                     axi_rready,
  output logic [2:0]               tl_a_opcode,
  output logic [2:0]               tl_a_param,
  output logic [2:0]               tl_a_size,
  output logic [SourceWidth-1:0]   tl_a_source,
  output logic [AddrWidth-1:0]     tl_a_address,
  output logic [DataWidth/8-1:0]   tl_a_mask,
  output logic [DataWidth-1:0]     tl_a_data,
  output logic                     tl_a_valid,
  input  logic                     tl_a_ready,
  input  logic [2:0]               tl_d_opcode,
  input  logic [2:0]               tl_d_size,
  input  logic [SourceWidth-1:0]   tl_d_source,
  input  logic [DataWidth-1:0]     tl_d_data,
  input  logic                     tl_d_error,
  input  logic                     tl_d_valid,
  output logic                     tl_d_ready
);
  localparam int MaskWidth = DataWidth / 8;
  localparam int OffWidth  = $clog2(MaskWidth);
  localparam logic [2:0] MaxSize = 3'(OffWidth);

  typedef enum logic [3:0] {
    IDLE, RD_A, RD_D, R_OUT, ERR_R, WR_W, WR_A, WR_D, B_OUT, ERR_W
  } state_e;

  state_e                 state_q, state_d;
  logic                   wr_first_q;
  logic [IdWidth-1:0]     id_q;
  logic [AddrWidth-1:0]   addr_q;
  logic [2:0]             size_q;
  logic [7:0]             cnt_q;
  logic                   err_q;
  logic [DataWidth-1:0]   data_q;
  logic [MaskWidth-1:0]   strb_q;

  function automatic logic [MaskWidth-1:0] size_mask(input logic [2:0] size);
    logic [MaskWidth-1:0] m;
    for (int i = 0; i < MaskWidth; i++) m[i] = (i < (1 << size));
    return m;
  endfunction

`ifdef AXI4_TLUL_ALIGN_CHECK_EN
  function automatic logic misaligned(input logic [AddrWidth-1:0] addr, input logic [2:0] size);
    logic [AddrWidth-1:0] low;
    low = (AddrWidth'(1) << size) - AddrWidth'(1);
    return |(addr & low);
  endfunction
`endif

  logic ar_err, aw_err;
  always_comb begin
    ar_err = (axi_arlen != 8'd0) || (axi_arsize > MaxSize);
    aw_err = (axi_awlen != 8'd0) || (axi_awsize > MaxSize);
`ifdef AXI4_TLUL_ALIGN_CHECK_EN
    ar_err = ar_err || misaligned(axi_araddr, axi_arsize);
    aw_err = aw_err || misaligned(axi_awaddr, axi_awsize);
`endif
  end

  // Only the granted channel sees ready; the priority bit breaks ties.
  logic idle, ar_grant, aw_grant;
  assign idle     = (state_q == IDLE);
  assign ar_grant = idle && axi_arvalid && (!axi_awvalid || !wr_first_q);
  assign aw_grant = idle && axi_awvalid && (!axi_arvalid || wr_first_q);

  logic [OffWidth-1:0]  offset, lane_offset;
  logic [MaskWidth-1:0] rd_mask, lane_mask;
  logic                 full_write;
  assign offset      = addr_q[OffWidth-1:0];
  assign lane_offset = (offset >> size_q) << size_q;
  assign rd_mask     = size_mask(size_q) << offset;
  assign lane_mask   = size_mask(size_q) << lane_offset;
  assign full_write  = (strb_q & lane_mask) == lane_mask;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_first_q <= 1'b0;
      id_q       <= '0;
      addr_q     <= '0;
      size_q     <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      data_q     <= '0;
      strb_q     <= '0;
    end else begin
      if (ar_grant || aw_grant) begin
        wr_first_q <= ~wr_first_q;
        id_q       <= ar_grant ? axi_arid   : axi_awid;
        addr_q     <= ar_grant ? axi_araddr : axi_awaddr;
        size_q     <= ar_grant ? axi_arsize : axi_awsize;
        cnt_q      <= ar_grant ? axi_arlen  : axi_awlen;
        err_q      <= ar_grant ? ar_err     : aw_err;
      end
      case (state_q)
        RD_D: if (tl_d_valid) begin
          data_q <= tl_d_data;
          err_q  <= tl_d_error;
        end
        WR_W: if (axi_wvalid) begin
          data_q <= axi_wdata;
          strb_q <= axi_wstrb;
        end
        WR_D:  if (tl_d_valid) err_q <= tl_d_error;
        ERR_R: if (axi_rready && cnt_q != 8'd0) cnt_q <= cnt_q - 8'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    axi_arready = ar_grant;
    axi_awready = aw_grant;
    axi_wready  = 1'b0;
    axi_rvalid  = 1'b0;
    axi_rlast   = 1'b0;
    axi_bvalid  = 1'b0;
    tl_a_valid  = 1'b0;
    tl_d_ready  = 1'b0;
    case (state_q)
      IDLE: begin
        if (ar_grant)      state_d = ar_err ? ERR_R : RD_A;
        else if (aw_grant) state_d = aw_err ? ERR_W : WR_W;
      end
      RD_A: begin
        tl_a_valid = 1'b1;
        if (tl_a_ready) state_d = RD_D;
      end
      RD_D: begin
        tl_d_ready = 1'b1;
        if (tl_d_valid) state_d = R_OUT;
      end
      R_OUT: begin
        axi_rvalid = 1'b1;
        axi_rlast  = 1'b1;
        if (axi_rready) state_d = IDLE;
      end
      ERR_R: begin
        axi_rvalid = 1'b1;
        axi_rlast  = (cnt_q == 8'd0);
        if (axi_rready && cnt_q == 8'd0) state_d = IDLE;
      end
      WR_W: begin
        axi_wready = 1'b1;
        if (axi_wvalid) state_d = WR_A;
      end
      WR_A: begin
        tl_a_valid = 1'b1;
        if (tl_a_ready) state_d = WR_D;
      end
      WR_D: begin
        tl_d_ready = 1'b1;
        if (tl_d_valid) state_d = B_OUT;
      end
      B_OUT: begin
        axi_bvalid = 1'b1;
        if (axi_bready) state_d = IDLE;
      end
      ERR_W: begin
        axi_wready = 1'b1;
        if (axi_wvalid && axi_wlast) state_d = B_OUT;
      end
      default: state_d = IDLE;
    endcase
  end

  assign axi_rid   = id_q;
  assign axi_rdata = (state_q == R_OUT) ? data_q : '0;
  assign axi_rresp = err_q ? 2'b10 : 2'b00;
  assign axi_bid   = id_q;
  assign axi_bresp = err_q ? 2'b10 : 2'b00;

  // A-channel fields come only from registers so they stay put while stalled.
  assign tl_a_opcode  = (state_q == WR_A) ? (full_write ? 3'd0 : 3'd1) : 3'd4;
  assign tl_a_param   = 3'd0;
  assign tl_a_size    = size_q;
  assign tl_a_source  = SourceWidth'(id_q);
  assign tl_a_address = addr_q;
  assign tl_a_mask    = (state_q == WR_A) ? strb_q : rd_mask;
  assign tl_a_data    = (state_q == WR_A) ? data_q : '0;

  logic unused_inputs;
  assign unused_inputs = ^{axi_awburst, axi_arburst, tl_d_opcode, tl_d_size, tl_d_source};
endmodule

// File: tb/tb_axi4_to_tlul.sv
// tb/tb_axi4_to_tlul.sv - scoreboard bench for axi4_to_tlul with a zero-wait TL responder.
module tb_axi4_to_tlul;
  localparam int DW = 64;
  localparam int AW = 32;
  localparam int IW = 8;
  localparam int SW = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [IW-1:0] axi_awid, axi_arid, axi_bid, axi_rid;
  logic [AW-1:0] axi_awaddr, axi_araddr;
  logic [7:0] axi_awlen, axi_arlen;
  logic [2:0] axi_awsize, axi_arsize;
  logic [1:0] axi_awburst, axi_arburst, axi_bresp, axi_rresp;
  logic axi_awvalid, axi_awready, axi_arvalid, axi_arready;
  logic [DW-1:0] axi_wdata, axi_rdata;
  logic [DW/8-1:0] axi_wstrb;
  logic axi_wlast, axi_wvalid, axi_wready;
  logic axi_bvalid, axi_bready, axi_rlast, axi_rvalid, axi_rready;
  logic [2:0] tl_a_opcode, tl_a_param, tl_a_size, tl_d_opcode, tl_d_size;
  logic [SW-1:0] tl_a_source, tl_d_source;
  logic [AW-1:0] tl_a_address;
  logic [DW/8-1:0] tl_a_mask;
  logic [DW-1:0] tl_a_data, tl_d_data;
  logic tl_a_valid, tl_a_ready, tl_d_error, tl_d_valid, tl_d_ready;

  axi4_to_tlul #(.DataWidth(DW), .AddrWidth(AW), .IdWidth(IW), .SourceWidth(SW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
    .axi_awsize(axi_awsize), .axi_awburst(axi_awburst),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
    .axi_arsize(axi_arsize), .axi_arburst(axi_arburst),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
    .tl_a_opcode(tl_a_opcode), .tl_a_param(tl_a_param), .tl_a_size(tl_a_size),
    .tl_a_source(tl_a_source), .tl_a_address(tl_a_address), .tl_a_mask(tl_a_mask),
    .tl_a_data(tl_a_data), .tl_a_valid(tl_a_valid), .tl_a_ready(tl_a_ready),
    .tl_d_opcode(tl_d_opcode), .tl_d_size(tl_d_size), .tl_d_source(tl_d_source),
    .tl_d_data(tl_d_data), .tl_d_error(tl_d_error), .tl_d_valid(tl_d_valid),
    .tl_d_ready(tl_d_ready)
  );

  typedef struct {logic [IW-1:0] id; logic [AW-1:0] addr; logic [7:0] len; logic [2:0] size;} ax_t;
  typedef struct {logic [DW-1:0] data; logic [7:0] strb; logic last;} w_t;
  typedef struct {logic [2:0] op; logic [SW-1:0] src; logic [AW-1:0] addr;
                  logic [7:0] mask; logic [2:0] size; logic [DW-1:0] data;} a_t;
  typedef struct {logic [DW-1:0] data; logic err;} d_t;
  typedef struct {logic [IW-1:0] id; logic [DW-1:0] data; logic [1:0] resp; logic last;} r_t;
  typedef struct {logic [IW-1:0] id; logic [1:0] resp;} b_t;

  ax_t ar_q[$], aw_q[$];
  w_t  w_q[$];
  a_t  a_exp[$];
  d_t  d_q[$];
  r_t  r_exp[$];
  b_t  b_exp[$];
  bit  g_exp[$];

  int total = 0, bad = 0, cyc = 0, a_stall = 0;
  int t_ar = 0, t_rv = 0, t_w = 0, t_bv = 0;
  bit d_pending = 0, rv_prev = 0, bv_prev = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit all_done();
    return ar_q.size() == 0 && aw_q.size() == 0 && w_q.size() == 0 && a_exp.size() == 0 &&
           r_exp.size() == 0 && b_exp.size() == 0 && g_exp.size() == 0;
  endfunction

  task automatic step();
    a_t e;
    bit exp_w;
    @(negedge clk);
    cyc++;
    axi_arvalid = ar_q.size() != 0;
    if (axi_arvalid) {axi_arid, axi_araddr, axi_arlen, axi_arsize} =
        {ar_q[0].id, ar_q[0].addr, ar_q[0].len, ar_q[0].size};
    axi_awvalid = aw_q.size() != 0;
    if (axi_awvalid) {axi_awid, axi_awaddr, axi_awlen, axi_awsize} =
        {aw_q[0].id, aw_q[0].addr, aw_q[0].len, aw_q[0].size};
    axi_wvalid = w_q.size() != 0;
    if (axi_wvalid) {axi_wdata, axi_wstrb, axi_wlast} = {w_q[0].data, w_q[0].strb, w_q[0].last};
    if (tl_a_valid && a_stall > 0) begin
      tl_a_ready = 1'b0;
      a_stall--;
    end else tl_a_ready = 1'b1;
    tl_d_valid = d_pending && d_q.size() != 0;
    if (tl_d_valid) {tl_d_data, tl_d_error} = {d_q[0].data, d_q[0].err};
    #1;
    chk("r_b_exclusive", axi_rvalid & axi_bvalid, 0);
    if ((axi_arvalid && axi_arready) || (axi_awvalid && axi_awready)) begin
      chk("grant_expected", g_exp.size() != 0, 1);
      if (g_exp.size() != 0) begin
        exp_w = g_exp.pop_front();
        chk("grant_order", {axi_arready, axi_awready}, exp_w ? 2'b01 : 2'b10);
      end
    end
    if (axi_arvalid && axi_arready) begin void'(ar_q.pop_front()); t_ar = cyc; end
    if (axi_awvalid && axi_awready) void'(aw_q.pop_front());
    if (axi_wvalid && axi_wready) begin void'(w_q.pop_front()); t_w = cyc; end
    if (tl_a_valid) begin
      chk("tl_a_expected", a_exp.size() != 0, 1);
      if (a_exp.size() != 0) begin
        e = a_exp[0];
        chk("tl_a_fields",
            {tl_a_opcode, tl_a_param, tl_a_size, tl_a_source, tl_a_address, tl_a_mask,
             (e.op == 3'd4) ? 64'h0 : tl_a_data},
            {e.op, 3'd0, e.size, e.src, e.addr, e.mask, e.data});
        if (tl_a_ready) begin void'(a_exp.pop_front()); d_pending = 1; end
      end
    end
    if (tl_d_valid && tl_d_ready) begin void'(d_q.pop_front()); d_pending = 0; end
    if (axi_rvalid) begin
      if (!rv_prev) t_rv = cyc;
      chk("r_expected", r_exp.size() != 0, 1);
      if (r_exp.size() != 0) begin
        chk("r_beat", {axi_rid, axi_rdata, axi_rresp, axi_rlast},
            {r_exp[0].id, r_exp[0].data, r_exp[0].resp, r_exp[0].last});
        if (axi_rready) void'(r_exp.pop_front());
      end
    end
    if (axi_bvalid) begin
      if (!bv_prev) t_bv = cyc;
      chk("b_expected", b_exp.size() != 0, 1);
      if (b_exp.size() != 0) begin
        chk("b_resp", {axi_bid, axi_bresp}, {b_exp[0].id, b_exp[0].resp});
        if (axi_bready) void'(b_exp.pop_front());
      end
    end
    rv_prev = axi_rvalid;
    bv_prev = axi_bvalid;
  endtask

  task automatic run(input string tag, input int max);
    for (int n = 0; n < max && !all_done(); n++) step();
    chk(tag, all_done(), 1);
    step();
  endtask

  task automatic push_ar(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size);
    ar_q.push_back('{id: id, addr: addr, len: len, size: size});
    g_exp.push_back(1'b0);
  endtask

  task automatic push_aw(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size);
    aw_q.push_back('{id: id, addr: addr, len: len, size: size});
    g_exp.push_back(1'b1);
  endtask

  task automatic push_a(input logic [2:0] op, input logic [7:0] src, input logic [31:0] addr,
                        input logic [7:0] mask, input logic [2:0] size, input logic [63:0] data);
    a_exp.push_back('{op: op, src: src, addr: addr, mask: mask, size: size, data: data});
  endtask

  initial begin
    rst_n = 1'b0;
    {axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awvalid} = '0;
    {axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arvalid} = '0;
    {axi_wdata, axi_wstrb, axi_wlast, axi_wvalid} = '0;
    axi_bready = 1'b1;
    axi_rready = 1'b1;
    {tl_a_ready, tl_d_valid, tl_d_data, tl_d_error} = '0;
    {tl_d_opcode, tl_d_size, tl_d_source} = '0;
    axi_awburst = 2'b01;
    axi_arburst = 2'b01;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_outputs", {axi_arready, axi_awready, axi_wready, axi_rvalid, axi_bvalid,
                          tl_a_valid, tl_d_ready}, 7'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Aligned 8-byte read.
    push_ar(8'h05, 32'h1000, 8'd0, 3'd3);
    push_a(3'd4, 8'h05, 32'h1000, 8'hFF, 3'd3, 64'h0);
    d_q.push_back('{data: 64'hDEADBEEF_CAFEF00D, err: 1'b0});
    r_exp.push_back('{id: 8'h05, data: 64'hDEADBEEF_CAFEF00D, resp: 2'b00, last: 1'b1});
    run("read_basic_done", 40);
    chk("read_latency", t_rv - t_ar, 3);

    // Full-lane write answered with a TL error.
    push_aw(8'h3A, 32'h2004, 8'd0, 3'd2);
    w_q.push_back('{data: 64'h11223344_55667788, strb: 8'hF0, last: 1'b1});
    push_a(3'd0, 8'h3A, 32'h2004, 8'hF0, 3'd2, 64'h11223344_55667788);
    d_q.push_back('{data: 64'h0, err: 1'b1});
    b_exp.push_back('{id: 8'h3A, resp: 2'b10});
    run("write_full_done", 40);
    chk("write_latency", t_bv - t_w, 3);

    // Contending AR/AW: grants go read, write, read; first A beat stalled two cycles.
    push_ar(8'h21, 32'h1100, 8'd0, 3'd3);
    push_aw(8'h22, 32'h2004, 8'd0, 3'd2);
    push_ar(8'h23, 32'h1204, 8'd0, 3'd2);
    w_q.push_back('{data: 64'hA5A5A5A5_5A5A5A5A, strb: 8'h30, last: 1'b1});
    push_a(3'd4, 8'h21, 32'h1100, 8'hFF, 3'd3, 64'h0);
    push_a(3'd1, 8'h22, 32'h2004, 8'h30, 3'd2, 64'hA5A5A5A5_5A5A5A5A);
    push_a(3'd4, 8'h23, 32'h1204, 8'hF0, 3'd2, 64'h0);
    d_q.push_back('{data: 64'h01234567_89ABCDEF, err: 1'b0});
    d_q.push_back('{data: 64'h0, err: 1'b0});
    d_q.push_back('{data: 64'hFEDCBA98_76543210, err: 1'b1});
    r_exp.push_back('{id: 8'h21, data: 64'h01234567_89ABCDEF, resp: 2'b00, last: 1'b1});
    b_exp.push_back('{id: 8'h22, resp: 2'b00});
    r_exp.push_back('{id: 8'h23, data: 64'hFEDCBA98_76543210, resp: 2'b10, last: 1'b1});
    a_stall = 2;
    run("contend_done", 80);

    // Burst read: four local SLVERR beats, rready stalled mid-burst.
    push_ar(8'h09, 32'h3000, 8'd3, 3'd3);
    for (int i = 0; i < 4; i++)
      r_exp.push_back('{id: 8'h09, data: 64'h0, resp: 2'b10, last: (i == 3)});
    for (int n = 0; n < 30 && r_exp.size() > 2; n++) step();
    chk("burst_progress", r_exp.size(), 2);
    axi_rready = 1'b0;
    step();
    step();
    axi_rready = 1'b1;
    run("burst_read_done", 30);

    // Oversize read completes locally with a single SLVERR beat.
    push_ar(8'h11, 32'h5000, 8'd0, 3'd4);
    r_exp.push_back('{id: 8'h11, data: 64'h0, resp: 2'b10, last: 1'b1});
    run("oversize_read_done", 30);

    // Burst write: three beats drained, one SLVERR response.
    push_aw(8'h44, 32'h4000, 8'd2, 3'd3);
    for (int i = 0; i < 3; i++)
      w_q.push_back('{data: 64'(i + 1), strb: 8'hFF, last: (i == 2)});
    b_exp.push_back('{id: 8'h44, resp: 2'b10});
    run("burst_write_done", 30);

    // Misaligned 4-byte read.
    push_ar(8'h02, 32'h1002, 8'd0, 3'd2);
`ifdef AXI4_TLUL_ALIGN_CHECK_EN
    r_exp.push_back('{id: 8'h02, data: 64'h0, resp: 2'b10, last: 1'b1});
`else
    push_a(3'd4, 8'h02, 32'h1002, 8'h3C, 3'd2, 64'h0);
    d_q.push_back('{data: 64'h0BAD_F00D_1234_5678, err: 1'b0});
    r_exp.push_back('{id: 8'h02, data: 64'h0BAD_F00D_1234_5678, resp: 2'b00, last: 1'b1});
`endif
    run("misaligned_done", 30);

    // A stray D beat in IDLE must not be accepted.
    @(negedge clk);
    tl_d_valid = 1'b1;
    #1;
    chk("idle_quiet", {axi_arready, axi_awready, axi_wready, axi_rvalid, axi_bvalid,
                       tl_a_valid, tl_d_ready}, 7'b0);
    tl_d_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
